// File: rtl/cluster_size_finder.sv
// Two-stage S-bit cluster finder: marks every cluster seed in a frame, its size,
// optional splitting of long runs into chained clusters, and truncation accounting.
module cluster_size_finder #(
  parameter int MXSBITS   = 64,
  parameter int CNTB      = 3,
  parameter int MAXCHUNKS = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [MXSBITS-1:0]      sbits_i,
  input  logic                    valid_i,
  input  logic                    split_en_i,
  input  logic                    trunc_clr_i,
  output logic [MXSBITS-1:0]      seed_o,
  output logic [MXSBITS*CNTB-1:0] cnt_o,
  output logic                    valid_o,
  output logic                    trunc_o,
  output logic [15:0]             trunc_cnt_o
);

  localparam int MAXCNT = (2 ** CNTB) - 1;
  localparam int CHUNK  = MAXCNT + 1;
  localparam int LOOKB  = MAXCHUNKS * CHUNK;
  localparam int PADW   = LOOKB + MXSBITS + MAXCNT;

  logic [MXSBITS-1:0]      sbits_q, sbits_d;
  logic                    splitEn_q, splitEn_d;
  logic                    validS1_q;
  logic                    validS2_q;
  logic [MXSBITS-1:0]      seed_q, seed_d;
  logic [MXSBITS*CNTB-1:0] cnt_q, cnt_d;
  logic                    trunc_q, trunc_d;
  logic [15:0]             truncCnt_q, truncCnt_d;

  logic [MXSBITS-1:0]      seedVec;
  logic [MXSBITS*CNTB-1:0] cntVec;
  logic [MXSBITS-1:0]      truncVec;
  logic [PADW-1:0]         padded;

  // Zero guard bands at both ends make the frame edges behave as non-wrapping 0 pads.
  assign padded = {{MAXCNT{1'b0}}, sbits_q, {LOOKB{1'b0}}};

  for (genvar i = 0; i < MXSBITS; i++) begin : g_pad
    int   runOffset;
    int   fwdOnes;
    logic lookOn;
    logic fwdOn;
    logic padSeed;
    logic padTrunc;

    // Offset within the run saturates at LOOKB, enough to decide both split and truncation.
    always_comb begin
      runOffset = 0;
      fwdOnes   = 0;
      lookOn    = 1'b1;
      fwdOn     = 1'b1;
      for (int j = 1; j <= LOOKB; j++) begin
        lookOn = lookOn & padded[i + LOOKB - j];
        if (lookOn) runOffset = j;
      end
      for (int j = 1; j <= MAXCNT; j++) begin
        fwdOn = fwdOn & padded[i + LOOKB + j];
        if (fwdOn) fwdOnes = j;
      end
      padSeed  = 1'b0;
      padTrunc = 1'b0;
      if (padded[i + LOOKB]) begin
        if (splitEn_q) begin
          padSeed  = (runOffset < LOOKB) && ((runOffset % CHUNK) == 0);
          padTrunc = (runOffset >= LOOKB);
        end else begin
          padSeed  = (runOffset == 0);
          padTrunc = (runOffset >= CHUNK);
        end
      end
    end

    assign seedVec[i]                 = padSeed;
    assign truncVec[i]                = padTrunc;
    assign cntVec[i*CNTB +: CNTB]     = padSeed ? CNTB'(fwdOnes) : '0;
  end

  always_comb begin
    sbits_d   = valid_i ? sbits_i : '0;
    splitEn_d = valid_i & split_en_i;
    seed_d    = validS1_q ? seedVec : '0;
    cnt_d     = validS1_q ? cntVec : '0;
    trunc_d   = validS1_q & (|truncVec);
    truncCnt_d = truncCnt_q;
    // Clear wins over an increment landing on the same edge.
    if (trunc_clr_i) begin
      truncCnt_d = '0;
    end else if (trunc_d && (truncCnt_q != 16'hFFFF)) begin
      truncCnt_d = truncCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sbits_q    <= '0;
      splitEn_q  <= 1'b0;
      validS1_q  <= 1'b0;
      validS2_q  <= 1'b0;
      seed_q     <= '0;
      cnt_q      <= '0;
      trunc_q    <= 1'b0;
      truncCnt_q <= '0;
    end else begin
      sbits_q    <= sbits_d;
      splitEn_q  <= splitEn_d;
      validS1_q  <= valid_i;
      validS2_q  <= validS1_q;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      trunc_q    <= trunc_d;
      truncCnt_q <= truncCnt_d;
    end
  end

  assign seed_o      = seed_q;
  assign cnt_o       = cnt_q;
  assign valid_o     = validS2_q;
  assign trunc_o     = trunc_q;
  assign trunc_cnt_o = truncCnt_q;

endmodule
